// File: rtl/pause_manager.sv
// Multi-source pause controller: synchronises and debounces N_CH pause inputs and a step button,
// then ORs the channel states into one pause flag and gates the datapath tick.
module pause_manager #(
  parameter int              N_CH        = 2,
  parameter int              DEB_CYCLES  = 50000,
  parameter logic [N_CH-1:0] TOGGLE_MASK = 2'b10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] pause_in,
  input  logic            step_btn,
  input  logic            tick,
  output logic            pause,
  output logic [N_CH-1:0] pause_src,
  output logic            pause_rise,
  output logic            pause_fall,
  output logic            run_tick
);

  localparam int NI = N_CH + 1;
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  // index N_CH of every per-input vector is the step button
  logic [NI-1:0] raw;
  logic [NI-1:0] sync1;
  logic [NI-1:0] sync2;
  logic [NI-1:0] db;
  logic [NI-1:0] db_nxt;
  logic [NI-1:0] db_d;
  logic [CW-1:0] cnt     [NI];
  logic [CW-1:0] cnt_nxt [NI];

  logic [N_CH-1:0] src_nxt;
  logic            next_pause;
  logic            step_rise;
  logic            step_pending;
  logic            pending_nxt;
  logic            run_tick_nxt;

  assign raw = {step_btn, pause_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // accept the synced value once it has differed from db for DEB_CYCLES consecutive cycles
  always_comb begin
    for (int i = 0; i < NI; i++) begin
      db_nxt[i]  = db[i];
      cnt_nxt[i] = cnt[i];
      if (sync2[i] == db[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        db_nxt[i]  = sync2[i];
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < NI; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      db   <= db_nxt;
      db_d <= db;
      for (int i = 0; i < NI; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // toggle channels flip on a debounced press only; level channels follow db
  always_comb begin
    src_nxt = pause_src;
    for (int i = 0; i < N_CH; i++) begin
      if (TOGGLE_MASK[i]) begin
        src_nxt[i] = pause_src[i] ^ (db[i] & ~db_d[i]);
      end else begin
        src_nxt[i] = db[i];
      end
    end
  end

  assign next_pause = |pause_src;
  assign step_rise  = db[N_CH] & ~db_d[N_CH];

  // a pending step is dropped whenever pause is (or is about to be) 0
  always_comb begin
    pending_nxt  = step_pending;
    run_tick_nxt = tick & (~pause | step_pending);
    if (!pause || !next_pause) begin
      pending_nxt = 1'b0;
    end else if (step_rise) begin
      pending_nxt = 1'b1;
    end else if (tick && step_pending) begin
      pending_nxt = 1'b0;
    end else begin
      pending_nxt = step_pending;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pause_src    <= '0;
      pause        <= 1'b0;
      pause_rise   <= 1'b0;
      pause_fall   <= 1'b0;
      run_tick     <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      pause_src    <= src_nxt;
      pause        <= next_pause;
      pause_rise   <= next_pause & ~pause;
      pause_fall   <= ~next_pause & pause;
      run_tick     <= run_tick_nxt;
      step_pending <= pending_nxt;
    end
  end

endmodule

// File: doc/pause_manager.md
Name: pause_manager

Overview:
- Parametrised successor to the single-switch pause register.
- Takes N_CH pause sources. Each source is a level switch or a push-button toggle, selected per channel by a mask. Every source is synchronised and debounced.
- Sources are OR-combined into one pause flag, with rise and fall pulses.
- A debounced step button gives single-tick advance while paused.
- Sits between the board switches/buttons and the mode/counter datapath. The datapath advances only on run_tick.

Parameters:
- N_CH, 2, number of pause source channels (>=1).
- DEB_CYCLES, 50000, consecutive clk cycles an input must differ from its debounced value before it is accepted (>=1).
- TOGGLE_MASK, 2'b10, N_CH bits. Bit i=1: channel i is a push-button toggle. Bit i=0: channel i is a level switch.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pause_in  in  N_CH  raw asynchronous pause inputs (switches/buttons)
- step_btn  in  1  raw asynchronous single-step button
- tick  in  1  one-cycle enable pulse from the clock divider
- pause  out  1  registered OR of all channel states
- pause_src  out  N_CH  registered per-channel pause state
- pause_rise  out  1  one-cycle pulse in the first cycle pause reads 1
- pause_fall  out  1  one-cycle pulse in the first cycle pause reads 0
- run_tick  out  1  registered gated tick for the datapath

Behaviour:
- Reset (sync, active-high, on the clk edge) clears:
  - all synchroniser flops, debounced values, debounce counters and edge-detect flops;
  - pause_src, pause, pause_rise, pause_fall, run_tick and step_pending.
  - Reset has priority over every other event and aborts in-progress debounce counts.
- Synchroniser: 2-flop chain per input (N_CH+1 chains).
- Debounce, per input:
  - Counter width is clog2(DEB_CYCLES+1).
  - If the synced value equals the debounced value db, the counter clears.
  - Otherwise the counter increments. When it would reach DEB_CYCLES, db takes the synced value and the counter clears.
  - A mismatch shorter than DEB_CYCLES cycles never changes db.
- Channel state, updated one edge after db changes:
  - Level channel: pause_src[i] = db[i].
  - Toggle channel: pause_src[i] inverts on each db rising edge (db=1, db_d=0). Release has no effect.
- pause = |pause_src, registered one edge later.
  - Total latency from the first edge sampling a stable new raw level to pause changing: DEB_CYCLES+4 edges.
- pause_rise / pause_fall are registered together with pause:
  - pause_rise = next_pause & ~pause.
  - pause_fall = ~next_pause & pause.
  - They are never asserted simultaneously and never for more than one cycle per transition.
- Step:
  - A step db rising edge while pause=1 sets step_pending.
  - While pause=0 the step button is ignored.
  - step_pending saturates at 1; extra presses before a tick do not queue.
  - step_pending clears when consumed by a tick, or in the cycle pause reads 0.
- run_tick (registered, 1 cycle latency) = tick & (~pause | step_pending). When step_pending is used, it clears on that same edge.
- Simultaneous events:
  - A step edge and a tick in the same cycle: pending is set on that edge and consumed by the next tick.
  - pause falling and pending set in the same cycle: pending clears.
- A toggle button held through reset release is treated as a new press. pause_src[i] becomes 1 DEB_CYCLES+3 edges after reset deasserts.
- Channel states are independent. pause stays 1 while any pause_src bit is 1.

Test Plan (N_CH=2, DEB_CYCLES=4, TOGGLE_MASK=2'b10):
- Reset, all inputs 0 -> all outputs 0. Hold pause_in[0]=1 -> pause=1 exactly 8 edges after the first sampling edge, pause_rise high for 1 cycle, pause_src=2'b01. Release -> pause=0 after 8 edges, one pause_fall pulse.
- Glitch: pause_in[0]=1 for 3 cycles then 0; also 1 for 3, 0 for 1, 1 for 3 -> pause stays 0, no pulses.
- Toggle: pause_in[1] pressed 6 cycles and released -> pause_src=2'b10, pause=1 and held after release. Second press -> pause=0, one fall pulse.
- Step: tick every 4 cycles, pause=1 -> no run_tick.
  - One step press -> exactly one run_tick, on the first tick after step_pending sets.
  - Two presses between ticks -> still one run_tick.
  - Step press while pause=0 -> run_tick follows tick unchanged, with no extra pulse.
- Overlap: ch1 toggled on, then ch0 level on/off -> pause_src goes 2'b10 -> 2'b11 -> 2'b10, pause stays 1 with no rise/fall pulses. Toggling ch1 off -> pause_fall once.
- Reset mid-operation: pause=1 with a debounce count in progress -> all outputs 0 on the reset edge. With pause_in[0] still held after reset deasserts -> pause=1 again after 8 edges.
